// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the writeback arbiter and its FIFO.
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Queue of long-latency writeback results with per-entry valid bits.
// Entries can be cancelled in place by address and searched by two read ports.
module wb_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [AW-1:0]    i_pushAddr,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    input  logic             i_killEn,
    input  logic [AW-1:0]    i_killAddr,
    input  logic [AW-1:0]    i_rdAddr1,
    input  logic [AW-1:0]    i_rdAddr2,
    output logic             o_full,
    output logic             o_notEmpty,
    output logic             o_headValid,
    output logic [AW-1:0]    o_headAddr,
    output logic [WIDTH-1:0] o_headData,
    output logic             o_hit1,
    output logic             o_hit2,
    output logic [CW-1:0]    o_validCount
);
    import mips_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;

    logic             w_match1;
    logic             w_match2;
    logic [CW-1:0]    w_validCount;

    // Valid bits are cleared on pop, so a set bit always marks a live occupied slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_vld   <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_killEn && (r_addr[i] == i_killAddr)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (i_pop) begin
                r_vld[r_rdPtr] <= 1'b0;
                r_rdPtr        <= r_rdPtr + PW'(1);
            end
            if (i_push) begin
                r_addr[r_wrPtr] <= i_pushAddr;
                r_data[r_wrPtr] <= i_pushData;
                r_vld[r_wrPtr]  <= !(i_killEn && (i_pushAddr == i_killAddr));
                r_wrPtr         <= r_wrPtr + PW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_comb begin
        w_match1     = 1'b0;
        w_match2     = 1'b0;
        w_validCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == i_rdAddr1)) w_match1 = 1'b1;
            if (r_vld[i] && (r_addr[i] == i_rdAddr2)) w_match2 = 1'b1;
            w_validCount = w_validCount + CW'(r_vld[i]);
        end
    end

    assign o_full       = (r_count == CW'(DEPTH));
    assign o_notEmpty   = (r_count != '0);
    assign o_headValid  = r_vld[r_rdPtr];
    assign o_headAddr   = r_addr[r_rdPtr];
    assign o_headData   = r_data[r_rdPtr];
    assign o_hit1       = w_match1 && (i_rdAddr1 != AW'(REG_ZERO));
    assign o_hit2       = w_match2 && (i_rdAddr2 != AW'(REG_ZERO));
    assign o_validCount = w_validCount;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write-port driver for the register file: pipeline writeback wins,
// queued long-latency results fill idle cycles, pending hits feed decode stalls.
module regfile_wb_arbiter #(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int AW    = mips_pkg::AW,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         pipe_valid,
    input  logic [AW-1:0]                pipe_addr,
    input  logic [WIDTH-1:0]             pipe_data,
    input  logic                         lr_valid,
    output logic                         lr_ready,
    input  logic [AW-1:0]                lr_addr,
    input  logic [WIDTH-1:0]             lr_data,
    input  logic [AW-1:0]                rdaddr1,
    input  logic [AW-1:0]                rdaddr2,
    output logic                         pend_hit1,
    output logic                         pend_hit2,
    output logic                         RegWrite,
    output logic [AW-1:0]                wraddr,
    output logic [WIDTH-1:0]             wrdata,
    output logic [$clog2(DEPTH+1)-1:0]   pend_count
);
    import mips_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic             r_regWrite;
    logic [AW-1:0]    r_wraddr;
    logic [WIDTH-1:0] r_wrdata;

    logic             w_pipeEff;
    logic             w_lrFire;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_notEmpty;
    logic             w_headValid;
    logic [AW-1:0]    w_headAddr;
    logic [WIDTH-1:0] w_headData;
    logic             w_fifoHit1;
    logic             w_fifoHit2;
    logic [CW-1:0]    w_validCount;

    assign w_pipeEff = pipe_valid && (pipe_addr != AW'(REG_ZERO));
    assign w_lrFire  = lr_valid && !w_full;
    assign w_push    = w_lrFire && (lr_addr != AW'(REG_ZERO));
    // A cancelled head never needs the write port, so it drains even under pipe traffic.
    assign w_pop     = w_notEmpty && (!w_headValid || !w_pipeEff);

    wb_fifo #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_wbFifo (
        .clock        (clock),
        .reset        (reset),
        .i_push       (w_push),
        .i_pushAddr   (lr_addr),
        .i_pushData   (lr_data),
        .i_pop        (w_pop),
        .i_killEn     (w_pipeEff),
        .i_killAddr   (pipe_addr),
        .i_rdAddr1    (rdaddr1),
        .i_rdAddr2    (rdaddr2),
        .o_full       (w_full),
        .o_notEmpty   (w_notEmpty),
        .o_headValid  (w_headValid),
        .o_headAddr   (w_headAddr),
        .o_headData   (w_headData),
        .o_hit1       (w_fifoHit1),
        .o_hit2       (w_fifoHit2),
        .o_validCount (w_validCount)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_regWrite <= 1'b0;
            r_wraddr   <= '0;
            r_wrdata   <= '0;
        end else if (w_pipeEff) begin
            r_regWrite <= 1'b1;
            r_wraddr   <= pipe_addr;
            r_wrdata   <= pipe_data;
        end else if (w_notEmpty && w_headValid) begin
            r_regWrite <= 1'b1;
            r_wraddr   <= w_headAddr;
            r_wrdata   <= w_headData;
        end else begin
            r_regWrite <= 1'b0;
        end
    end

    // A result being accepted this cycle is already pending from decode's view.
    assign pend_hit1  = w_fifoHit1 ||
                        (w_lrFire && (lr_addr == rdaddr1) && (rdaddr1 != AW'(REG_ZERO)));
    assign pend_hit2  = w_fifoHit2 ||
                        (w_lrFire && (lr_addr == rdaddr2) && (rdaddr2 != AW'(REG_ZERO)));

    assign lr_ready   = !w_full;
    assign pend_count = w_validCount;
    assign RegWrite   = r_regWrite;
    assign wraddr     = r_wraddr;
    assign wrdata     = r_wrdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a queue-based reference model
// and a register-file shadow that absorbs the arbiter's writes.
module tb_regfile_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset;
    logic             pipe_valid;
    logic [AW-1:0]    pipe_addr;
    logic [WIDTH-1:0] pipe_data;
    logic             lr_valid;
    logic             lr_ready;
    logic [AW-1:0]    lr_addr;
    logic [WIDTH-1:0] lr_data;
    logic [AW-1:0]    rdaddr1;
    logic [AW-1:0]    rdaddr2;
    logic             pend_hit1;
    logic             pend_hit2;
    logic             RegWrite;
    logic [AW-1:0]    wraddr;
    logic [WIDTH-1:0] wrdata;
    logic [CW-1:0]    pend_count;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        bit               vld;
    } entry_t;

    entry_t           mq[$];
    logic             mRegWrite;
    logic [AW-1:0]    mWraddr;
    logic [WIDTH-1:0] mWrdata;
    logic [WIDTH-1:0] mRegs [32];

    regfile_wb_arbiter #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .lr_valid   (lr_valid),
        .lr_ready   (lr_ready),
        .lr_addr    (lr_addr),
        .lr_data    (lr_data),
        .rdaddr1    (rdaddr1),
        .rdaddr2    (rdaddr2),
        .pend_hit1  (pend_hit1),
        .pend_hit2  (pend_hit2),
        .RegWrite   (RegWrite),
        .wraddr     (wraddr),
        .wrdata     (wrdata),
        .pend_count (pend_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int modelValidCount();
        int n = 0;
        foreach (mq[i]) if (mq[i].vld) n++;
        return n;
    endfunction

    function automatic bit modelHit(input logic [AW-1:0] ra);
        if (ra == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].vld && mq[i].addr == ra) return 1'b1;
        if (lr_valid && (mq.size() < DEPTH) && lr_addr == ra) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: pipe writes win, cancelled heads vanish for free,
    // valid heads take idle write slots, pipe writes cancel older queued results.
    always @(posedge clock or negedge reset) begin : modelStep
        bit     pe;
        bit     fire;
        bit     wr;
        bit     dropHead;
        entry_t e;
        if (!reset) begin
            mq.delete();
            mRegWrite = 1'b0;
            mWraddr   = '0;
            mWrdata   = '0;
        end else begin
            if (mRegWrite) mRegs[mWraddr] = mWrdata;
            pe       = pipe_valid && (pipe_addr != '0);
            fire     = lr_valid && (mq.size() < DEPTH);
            wr       = 1'b0;
            dropHead = 1'b0;
            if (pe) begin
                wr      = 1'b1;
                mWraddr = pipe_addr;
                mWrdata = pipe_data;
            end
            if (mq.size() > 0) begin
                if (!mq[0].vld) begin
                    dropHead = 1'b1;
                end else if (!pe) begin
                    dropHead = 1'b1;
                    wr       = 1'b1;
                    mWraddr  = mq[0].addr;
                    mWrdata  = mq[0].data;
                end
            end
            if (dropHead) void'(mq.pop_front());
            if (pe) foreach (mq[i]) if (mq[i].addr == pipe_addr) mq[i].vld = 1'b0;
            if (fire && lr_addr != '0) begin
                e.addr = lr_addr;
                e.data = lr_data;
                e.vld  = !(pe && lr_addr == pipe_addr);
                mq.push_back(e);
            end
            mRegWrite = wr;
        end
    end

    // Every cycle, away from the active edge, every output is held against the model.
    always @(negedge clock) begin
        checkOutput("RegWrite",   32'(RegWrite),   32'(mRegWrite));
        checkOutput("wraddr",     32'(wraddr),     32'(mWraddr));
        checkOutput("wrdata",     32'(wrdata),     32'(mWrdata));
        checkOutput("lr_ready",   32'(lr_ready),   32'(mq.size() < DEPTH));
        checkOutput("pend_count", 32'(pend_count), 32'(modelValidCount()));
        checkOutput("pend_hit1",  32'(pend_hit1),  32'(modelHit(rdaddr1)));
        checkOutput("pend_hit2",  32'(pend_hit2),  32'(modelHit(rdaddr2)));
    end

    task automatic applyStimulus(input logic pv, input logic [AW-1:0] pa, input logic [WIDTH-1:0] pd,
                                 input logic lv, input logic [AW-1:0] la, input logic [WIDTH-1:0] ld,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        pipe_valid = pv;
        pipe_addr  = pa;
        pipe_data  = pd;
        lr_valid   = lv;
        lr_addr    = la;
        lr_data    = ld;
        rdaddr1    = r1;
        rdaddr2    = r2;
        @(posedge clock);
        #1;
    endtask

    logic [AW-1:0]    pipeAddrs [4];
    logic [WIDTH-1:0] pipeDatas [4];

    initial begin
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        pipeAddrs[0] = 5'd1;  pipeDatas[0] = 32'd100;
        pipeAddrs[1] = 5'd4;  pipeDatas[1] = 32'd5;
        pipeAddrs[2] = 5'd8;  pipeDatas[2] = 32'd333;
        pipeAddrs[3] = 5'd16; pipeDatas[3] = 32'd2000;

        reset      = 1'b0;
        pipe_valid = 1'b1;
        pipe_addr  = 5'd3;
        pipe_data  = 32'd55;
        lr_valid   = 1'b0;
        lr_addr    = '0;
        lr_data    = '0;
        rdaddr1    = '0;
        rdaddr2    = '0;

        $display("[TB] reset held with a pipe request present");
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_RegWrite",   32'(RegWrite),   32'd0);
        checkOutput("rst_wraddr",     32'(wraddr),     32'd0);
        checkOutput("rst_wrdata",     wrdata,          32'd0);
        checkOutput("rst_lr_ready",   32'(lr_ready),   32'd1);
        checkOutput("rst_pend_count", 32'(pend_count), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("first_RegWrite", 32'(RegWrite), 32'd1);
        checkOutput("first_wraddr",   32'(wraddr),   32'd3);
        checkOutput("first_wrdata",   wrdata,        32'd55);

        $display("[TB] pipeline-only writes");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pipeAddrs[i], pipeDatas[i], 1'b0, '0, '0, '0, '0);
            checkOutput("pipe_RegWrite", 32'(RegWrite), 32'd1);
            checkOutput("pipe_wraddr",   32'(wraddr),   32'(pipeAddrs[i]));
            checkOutput("pipe_wrdata",   wrdata,        pipeDatas[i]);
        end
        applyStimulus(1'b1, 5'd0, 32'd999, 1'b0, '0, '0, '0, '0);
        checkOutput("r0_RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("r0_wraddr",   32'(wraddr),   32'd16);
        checkOutput("r0_wrdata",   wrdata,        32'd2000);
        checkOutput("reg1",        mRegs[1],      32'd100);
        checkOutput("reg16",       mRegs[16],     32'd2000);

        $display("[TB] queue fills under pipe traffic then drains");
        applyStimulus(1'b1, 5'd20, 32'd1, 1'b1, 5'd3, 32'd77, '0, '0);
        checkOutput("q1_pend_count", 32'(pend_count), 32'd1);
        applyStimulus(1'b1, 5'd21, 32'd2, 1'b1, 5'd5, 32'd88, '0, '0);
        checkOutput("q2_pend_count", 32'(pend_count), 32'd2);
        checkOutput("q2_lr_ready",   32'(lr_ready),   32'd0);
        applyStimulus(1'b1, 5'd22, 32'd3, 1'b1, 5'd6, 32'd99, '0, '0);
        checkOutput("q3_pend_count", 32'(pend_count), 32'd2);
        checkOutput("q3_wraddr",     32'(wraddr),     32'd22);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        checkOutput("d1_RegWrite",   32'(RegWrite),   32'd1);
        checkOutput("d1_wraddr",     32'(wraddr),     32'd3);
        checkOutput("d1_wrdata",     wrdata,          32'd77);
        checkOutput("d1_pend_count", 32'(pend_count), 32'd1);
        checkOutput("d1_lr_ready",   32'(lr_ready),   32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        checkOutput("d2_wraddr",     32'(wraddr),     32'd5);
        checkOutput("d2_wrdata",     wrdata,          32'd88);
        checkOutput("d2_pend_count", 32'(pend_count), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        checkOutput("d3_RegWrite",   32'(RegWrite),   32'd0);

        $display("[TB] younger pipe write cancels queued result");
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'd11, '0, '0);
        checkOutput("w1_pend_count", 32'(pend_count), 32'd1);
        checkOutput("w1_RegWrite",   32'(RegWrite),   32'd0);
        applyStimulus(1'b1, 5'd7, 32'd22, 1'b0, '0, '0, '0, '0);
        checkOutput("w2_wraddr",     32'(wraddr),     32'd7);
        checkOutput("w2_wrdata",     wrdata,          32'd22);
        checkOutput("w2_pend_count", 32'(pend_count), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        checkOutput("w3_RegWrite",   32'(RegWrite),   32'd0);
        checkOutput("w3_wrdata",     wrdata,          32'd22);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        checkOutput("w4_RegWrite",   32'(RegWrite),   32'd0);
        checkOutput("reg7",          mRegs[7],        32'd22);

        $display("[TB] pending-register hazard reporting");
        applyStimulus(1'b1, 5'd10, 32'd5, 1'b1, 5'd9, 32'd123, 5'd9, 5'd0);
        checkOutput("h1_pend_hit1",  32'(pend_hit1),  32'd1);
        applyStimulus(1'b1, 5'd11, 32'd6, 1'b0, '0, '0, 5'd9, 5'd0);
        checkOutput("h2_pend_hit1",  32'(pend_hit1),  32'd1);
        checkOutput("h2_pend_hit2",  32'(pend_hit2),  32'd0);
        checkOutput("h2_pend_count", 32'(pend_count), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0);
        checkOutput("h3_wraddr",     32'(wraddr),     32'd9);
        checkOutput("h3_wrdata",     wrdata,          32'd123);
        checkOutput("h3_pend_hit1",  32'(pend_hit1),  32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0);
        checkOutput("reg9",          mRegs[9],        32'd123);

        $display("[TB] asynchronous reset with two queued results");
        applyStimulus(1'b1, 5'd20, 32'd7, 1'b1, 5'd12, 32'd1, '0, '0);
        applyStimulus(1'b1, 5'd21, 32'd8, 1'b1, 5'd13, 32'd2, '0, '0);
        checkOutput("r1_pend_count", 32'(pend_count), 32'd2);
        pipe_valid = 1'b0;
        lr_valid   = 1'b0;
        #2 reset = 1'b0;
        #3;
        checkOutput("r2_pend_count", 32'(pend_count), 32'd0);
        checkOutput("r2_RegWrite",   32'(RegWrite),   32'd0);
        checkOutput("r2_wrdata",     wrdata,          32'd0);
        checkOutput("r2_lr_ready",   32'(lr_ready),   32'd1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
            checkOutput("r3_RegWrite", 32'(RegWrite), 32'd0);
        end

        @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
